// File: rtl/power_pkg.sv
// Shared widths, iteration count and FSM state type for the power_of_number block.
package power_pkg;

  localparam int OPERAND_W = 32;
  localparam int SQUARE_W  = 64;
  localparam int CUBE_W    = 96;
  localparam int ITER      = 32;
  localparam int CNT_W     = 5;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SQUARE = 2'd1,
    CUBE   = 2'd2
  } state_e;

endpackage

// File: rtl/seq_multiplier.sv
// LSB-first shift-add multiplier: one multiplier bit per enabled cycle.
// The accumulator's upper MCAND_W bits take the partial sum and the whole register
// shifts right by one each step.
// After OPERAND_W steps the accumulator holds the full product.
// prod_next exposes the value the accumulator would take on this edge.
// This lets the caller capture the final product on the same edge that clears it.
module seq_multiplier
  import power_pkg::*;
#(
  parameter int MCAND_W = 64
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          clear,
  input  logic                          en,
  input  logic [MCAND_W-1:0]            mcand,
  input  logic [OPERAND_W-1:0]          mplier,
  input  logic [CNT_W-1:0]              bit_idx,
  output logic [MCAND_W+OPERAND_W-1:0]  prod_next
);

  localparam int ACC_W = MCAND_W + OPERAND_W;

  logic [ACC_W-1:0]   acc_q, acc_d;
  logic [MCAND_W:0]   sum;

  // Add the selected partial product into the upper half, then shift right; clear wins over a step
  always_comb begin
    sum       = {1'b0, acc_q[ACC_W-1 -: MCAND_W]} + (mplier[bit_idx] ? {1'b0, mcand} : '0);
    prod_next = {sum, acc_q[OPERAND_W-1:1]};
    acc_d     = acc_q;
    if (clear) begin
      acc_d = '0;
    end else if (en) begin
      acc_d = prod_next;
    end
  end

  // Accumulator register with synchronous active-low reset
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      acc_q <= '0;
    end else begin
      acc_q <= acc_d;
    end
  end

endmodule

// File: rtl/power_of_number.sv
// Computes number^2 and number^3 with one shared 64x32 shift-add multiplier.
// The square phase and the cube phase take 32 cycles each.
//
//   state  | meaning
//   IDLE   | waiting for start; outputs hold last results
//   SQUARE | operand x operand, one multiplier bit per cycle
//   CUBE   | square x operand, one multiplier bit per cycle
module power_of_number
  import power_pkg::*;
(
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic [OPERAND_W-1:0]  number,
  output logic                  busy,
  output logic                  done,
  output logic [SQUARE_W-1:0]   square,
  output logic [CUBE_W-1:0]     cube
);

  localparam logic [CNT_W-1:0] LAST_ITER = CNT_W'(ITER - 1);

  state_e                 state_q, state_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic [OPERAND_W-1:0]   operand_q, operand_d;
  logic [SQUARE_W-1:0]    sq_hold_q, sq_hold_d;
  logic [SQUARE_W-1:0]    square_q, square_d;
  logic [CUBE_W-1:0]      cube_q, cube_d;
  logic                   busy_q, busy_d;
  logic                   done_q, done_d;

  logic                   mult_clear, mult_en;
  logic [SQUARE_W-1:0]    mult_mcand;
  logic [CUBE_W-1:0]      mult_next;

  seq_multiplier #(
    .MCAND_W (SQUARE_W)
  ) u_mult (
    .clk       (clk),
    .rst_n     (rst_n),
    .clear     (mult_clear),
    .en        (mult_en),
    .mcand     (mult_mcand),
    .mplier    (operand_q),
    .bit_idx   (cnt_q),
    .prod_next (mult_next)
  );

  // Next-state, counter and output-register logic for the two multiply phases
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    operand_d  = operand_q;
    sq_hold_d  = sq_hold_q;
    square_d   = square_q;
    cube_d     = cube_q;
    busy_d     = busy_q;
    done_d     = 1'b0;
    mult_clear = 1'b0;
    mult_en    = 1'b0;
    mult_mcand = (state_q == CUBE) ? sq_hold_q
                                   : {{(SQUARE_W-OPERAND_W){1'b0}}, operand_q};
    unique case (state_q)
      IDLE: begin
        if (start) begin
          operand_d  = number;
          mult_clear = 1'b1;
          cnt_d      = '0;
          busy_d     = 1'b1;
          state_d    = SQUARE;
        end
      end
      SQUARE: begin
        mult_en = 1'b1;
        cnt_d   = cnt_q + 1'b1;
        if (cnt_q == LAST_ITER) begin
          sq_hold_d  = mult_next[SQUARE_W-1:0];
          mult_clear = 1'b1;
          state_d    = CUBE;
        end
      end
      CUBE: begin
        mult_en = 1'b1;
        cnt_d   = cnt_q + 1'b1;
        if (cnt_q == LAST_ITER) begin
          square_d = sq_hold_q;
          cube_d   = mult_next;
          done_d   = 1'b1;
          busy_d   = 1'b0;
          state_d  = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
        busy_d  = 1'b0;
      end
    endcase
  end

  // State and registered outputs with synchronous active-low reset
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      operand_q <= '0;
      sq_hold_q <= '0;
      square_q  <= '0;
      cube_q    <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      operand_q <= operand_d;
      sq_hold_q <= sq_hold_d;
      square_q  <= square_d;
      cube_q    <= cube_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
    end
  end

  assign busy   = busy_q;
  assign done   = done_q;
  assign square = square_q;
  assign cube   = cube_q;

endmodule

// File: tb/tb_power_of_number.sv
// Testbench for power_of_number.
// A scoreboard queue of expected results is checked on every done pulse.
// Table vectors, hand-written corner sequences and random operands drive the design.
module tb_power_of_number;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         start;
  logic [31:0]  number;
  logic         busy;
  logic         done;
  logic [63:0]  square;
  logic [95:0]  cube;

  power_of_number dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .start  (start),
    .number (number),
    .busy   (busy),
    .done   (done),
    .square (square),
    .cube   (cube)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] num;
    logic [63:0] sq;
    logic [95:0] cu;
  } vec_t;

  typedef struct {
    logic [63:0] sq;
    logic [95:0] cu;
  } exp_t;

  exp_t sb_q[$];
  int   n_checks = 0;
  int   n_fail   = 0;
  int   done_cnt = 0;
  int   cyc      = 0;
  logic prev_done = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: actual %0h required %0h", name, act, exp);
    end
  endtask

  // Scoreboard: every done pulse must match the oldest outstanding expectation
  always @(negedge clk) begin
    if (done) begin
      done_cnt++;
      chk("done_single_cycle", 128'(prev_done), 128'(0));
      if (sb_q.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL unexpected_done: actual done with empty scoreboard at cycle %0d", cyc);
      end else begin
        exp_t e;
        e = sb_q.pop_front();
        chk("square", 128'(square), 128'(e.sq));
        chk("cube", 128'(cube), 128'(e.cu));
      end
    end
    prev_done = done;
  end

  function automatic exp_t model(input logic [31:0] n);
    exp_t e;
    e.sq = 64'(n) * 64'(n);
    e.cu = 96'(e.sq) * 96'(n);
    return e;
  endfunction

  // Start one operation at a negedge; the following posedge accepts it
  task automatic issue(input logic [31:0] n, input bit expect_result, output int c0);
    exp_t e;
    start  = 1'b1;
    number = n;
    c0     = cyc;
    if (expect_result) begin
      e = model(n);
      sb_q.push_back(e);
    end
    @(negedge clk);
    start = 1'b0;
  endtask

  // Wait for done; report busy cycles and whether outputs moved before done
  task automatic wait_done(output int busy_cycles, output bit moved);
    logic [63:0] sq0;
    logic [95:0] cu0;
    bit          seen;
    sq0 = square;
    cu0 = cube;
    busy_cycles = (busy === 1'b1) ? 1 : 0;
    moved = 1'b0;
    seen  = 1'b0;
    for (int i = 0; i < 100 && !seen; i++) begin
      if (done === 1'b1) begin
        seen = 1'b1;
      end else begin
        if (square !== sq0 || cube !== cu0) moved = 1'b1;
        @(negedge clk);
        if (busy === 1'b1 && done !== 1'b1) busy_cycles++;
      end
    end
    if (!seen) begin
      n_checks++;
      n_fail++;
      $display("FAIL done_timeout: actual no done within 100 cycles, required done");
    end
  endtask

  task automatic idle_cycles(input int n);
    for (int i = 0; i < n; i++) @(negedge clk);
  endtask

  vec_t vecs[7];
  int   c0, c1, bc, dc0;
  bit   mv;

  initial begin
    vecs[0] = '{32'd3,          64'd9,                  96'd27};
    vecs[1] = '{32'hFFFF_FFFF,  64'hFFFF_FFFE_0000_0001, 96'hFFFF_FFFD_0000_0002_FFFF_FFFF};
    vecs[2] = '{32'd0,          64'd0,                  96'd0};
    vecs[3] = '{32'd1,          64'd1,                  96'd1};
    vecs[4] = '{32'd2,          64'd4,                  96'd8};
    vecs[5] = '{32'd10,         64'd100,                96'd1000};
    vecs[6] = '{32'h0001_0000,  64'h1_0000_0000,        96'h1_0000_0000_0000};

    rst_n  = 1'b0;
    start  = 1'b0;
    number = '0;
    idle_cycles(3);
    chk("reset_busy", 128'(busy), 128'(0));
    chk("reset_done", 128'(done), 128'(0));
    chk("reset_square", 128'(square), 128'(0));
    chk("reset_cube", 128'(cube), 128'(0));
    rst_n = 1'b1;
    idle_cycles(2);

    // Table vectors: expected values come from the table, latency and busy width checked
    for (int v = 0; v < 7; v++) begin
      exp_t e;
      start  = 1'b1;
      number = vecs[v].num;
      c0     = cyc;
      e.sq   = vecs[v].sq;
      e.cu   = vecs[v].cu;
      sb_q.push_back(e);
      @(negedge clk);
      start = 1'b0;
      wait_done(bc, mv);
      chk("latency", 128'(cyc - c0), 128'(65));
      chk("busy_cycles", 128'(bc), 128'(64));
      chk("outputs_hold_while_busy", 128'(mv), 128'(0));
      chk("busy_low_at_done", 128'(busy), 128'(0));
      idle_cycles(2);
    end

    // Back-to-back: 0 then 1 with the second start in the done cycle
    issue(32'd0, 1'b1, c0);
    wait_done(bc, mv);
    c1 = cyc;
    issue(32'd1, 1'b1, c0);
    wait_done(bc, mv);
    chk("back_to_back_spacing", 128'(cyc - c1), 128'(65));
    idle_cycles(2);

    // start while busy is ignored; number changes do not leak into the result
    dc0 = done_cnt;
    issue(32'd5, 1'b1, c0);
    idle_cycles(9);
    start  = 1'b1;
    number = 32'd7;
    @(negedge clk);
    start = 1'b0;
    idle_cycles(100);
    chk("ignored_start_done_count", 128'(done_cnt - dc0), 128'(1));

    // Reset mid-operation aborts without done and clears outputs
    dc0 = done_cnt;
    issue(32'd10, 1'b0, c0);
    idle_cycles(29);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    chk("abort_busy", 128'(busy), 128'(0));
    chk("abort_square", 128'(square), 128'(0));
    chk("abort_cube", 128'(cube), 128'(0));
    idle_cycles(80);
    chk("abort_no_done", 128'(done_cnt - dc0), 128'(0));

    // start sampled during reset is ignored
    rst_n  = 1'b0;
    start  = 1'b1;
    number = 32'd9;
    @(negedge clk);
    rst_n = 1'b1;
    start = 1'b0;
    @(negedge clk);
    chk("start_in_reset_ignored", 128'(busy), 128'(0));

    issue(32'd2, 1'b1, c0);
    wait_done(bc, mv);
    chk("post_reset_latency", 128'(cyc - c0), 128'(65));

    // Random operands against the reference model, issued back-to-back
    for (int r = 0; r < 1000; r++) begin
      issue($urandom, 1'b1, c0);
      wait_done(bc, mv);
    end
    idle_cycles(3);
    chk("scoreboard_drained", 128'(sb_q.size()), 128'(0));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
